// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: start/stop session control, streamed tx/rx words,
// configurable word width, SCLK divider, CPOL/CPHA mode and bit order.
module spi_master_mc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 2,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              start_status,
  output logic              start_clear,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(2 * DATA_W);
  localparam int unsigned BIT_W = CNT_W - 1;

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  edge_cnt;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_sh;
  logic              stop_pend;

  logic              tick;
  logic              last_edge;
  logic [BIT_W-1:0]  half;
  logic [BIT_W-1:0]  drive_k;
  logic              drive_en;
  logic              sample_en;
  logic [CS_W-1:0]   sel_idx;

  function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] k);
    return MSB_FIRST ? (BIT_W'(DATA_W - 1) - k) : k;
  endfunction

  // edge_cnt counts sclk edges 0-based; half is the bit number of the edge pair.
  // CPHA=0 launches bit k on edge 2k (cnt odd), so its index is one ahead of half.
  always_comb begin
    tick      = (div == DIV_W'(CLK_DIV - 1));
    last_edge = (edge_cnt == CNT_W'(2 * DATA_W - 1));
    half      = edge_cnt[CNT_W-1:1];
    drive_k   = CPHA ? half : (half + 1'b1);
    drive_en  = CPHA ? ~edge_cnt[0] : (edge_cnt[0] & ~last_edge);
    sample_en = (edge_cnt[0] == CPHA);
    sel_idx   = (32'(cs_sel) < NUM_CS) ? cs_sel : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      edge_cnt     <= '0;
      tx_word      <= '0;
      rx_sh        <= '0;
      stop_pend    <= 1'b0;
      tx_ready     <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      start_status <= 1'b0;
      start_clear  <= 1'b0;
      sclk         <= CPOL;
      mosi         <= 1'b0;
      cs_n         <= '1;
    end else begin
      rx_valid    <= 1'b0;
      start_clear <= 1'b0;

      if (state inside {SETUP, SHIFT, HOLD}) begin
        div <= tick ? '0 : div + 1'b1;
        if (stop) stop_pend <= 1'b1;
      end else begin
        div <= '0;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= WAIT;
            start_status <= 1'b1;
            stop_pend    <= 1'b0;
            cs_n         <= ~(NUM_CS'(1) << sel_idx);
          end
        end
        WAIT: begin
          if (stop || stop_pend) begin
            state        <= DONE;
            tx_ready     <= 1'b0;
            cs_n         <= '1;
            start_clear  <= 1'b1;
            start_status <= 1'b0;
          end else if (tx_valid && tx_ready) begin
            state    <= SETUP;
            tx_ready <= 1'b0;
            tx_word  <= tx_data;
            edge_cnt <= '0;
            if (!CPHA) mosi <= tx_data[bit_pos('0)];
          end else begin
            tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (tick) begin
            state    <= SHIFT;
            edge_cnt <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (drive_en)  mosi <= tx_word[bit_pos(drive_k)];
            if (sample_en) rx_sh[bit_pos(half)] <= miso;
            if (last_edge) begin
              state    <= HOLD;
              edge_cnt <= '0;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
            if (stop_pend || stop) begin
              state        <= DONE;
              cs_n         <= '1;
              start_clear  <= 1'b1;
              start_status <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
          mosi      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc: a mode-0 MSB-first loopback instance
// and a CPOL=1/CPHA=1 LSB-first instance talking to a simple slave model.
module tb_spi_master_mc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // mode 0, MSB first, loopback
  logic       start0 = 1'b0, stop0 = 1'b0, cs_sel0 = 1'b0, tx_valid0 = 1'b0;
  logic [7:0] tx_data0 = '0;
  logic       tx_ready0, rx_valid0, status0, clr0, sclk0, mosi0, miso0;
  logic [7:0] rx_data0;
  logic [1:0] cs_n0;
  assign miso0 = mosi0;

  // mode 3, LSB first, slave model
  logic       start3 = 1'b0, stop3 = 1'b0, cs_sel3 = 1'b0, tx_valid3 = 1'b0;
  logic [7:0] tx_data3 = '0;
  logic       tx_ready3, rx_valid3, status3, clr3, sclk3, mosi3;
  logic       miso3 = 1'b0;
  logic [7:0] rx_data3;
  logic [1:0] cs_n3;

  spi_master_mc #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .cs_sel(cs_sel0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .start_status(status0), .start_clear(clr0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
  );

  spi_master_mc #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop(stop3), .cs_sel(cs_sel3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .start_status(status3), .start_clear(clr3),
    .sclk(sclk3), .mosi(mosi3), .miso(miso3), .cs_n(cs_n3)
  );

  int n_cmp = 0, n_err = 0;
  int n_rxv0 = 0, n_clr0 = 0, n_rdy0 = 0, n_cshi0 = 0, n_clr3 = 0, n_both = 0, n_clrst = 0;
  int n_sr0 = 0, acc_sr0 = 0, acc_cshi0 = 0;

  // per-cycle event counters, sampled at the rising edge (pre-update values)
  always @(posedge clk) begin
    n_rxv0  += int'(rx_valid0);
    n_clr0  += int'(clr0);
    n_rdy0  += int'(tx_ready0);
    n_cshi0 += int'(cs_n0[0]);
    n_clr3  += int'(clr3);
    n_both  += int'(rx_valid0 & tx_ready0) + int'(rx_valid3 & tx_ready3);
    n_clrst += int'(clr0 & status0) + int'(clr3 & status3);
  end

  always @(posedge sclk0) n_sr0 += 1;

  // slave for instance 3: launches on the leading (falling) edge, LSB first
  logic [7:0] slave_word = 8'hC3;
  logic [7:0] mosi_cap = '0;
  int s_idx = 0, m_idx = 0;
  always @(negedge sclk3) if (cs_n3[0] === 1'b0 && s_idx < 8) begin
    miso3 = slave_word[s_idx];
    s_idx += 1;
  end
  always @(posedge sclk3) if (cs_n3[0] === 1'b0 && m_idx < 8) begin
    mosi_cap[m_idx] = mosi3;
    m_idx += 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return tx_ready0;
      1: return rx_valid0;
      3: return tx_ready3;
      4: return rx_valid3;
      default: return 1'b0;
    endcase
  endfunction

  // lat = number of falling edges until the signal is seen high, -1 on timeout
  task automatic wait_for(input int which, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (sig(which) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic ctl(input int d, input logic s, input logic p, input logic sel);
    @(negedge clk);
    if (d == 0) begin start0 = s; stop0 = p; cs_sel0 = sel; end
    else        begin start3 = s; stop3 = p; cs_sel3 = sel; end
    @(negedge clk);
    start0 = 1'b0; stop0 = 1'b0; start3 = 1'b0; stop3 = 1'b0;
  endtask

  task automatic accept(input int d, input logic [7:0] data);
    int w;
    wait_for(d == 0 ? 0 : 3, 50, w);
    check("tx_ready_seen", 32'(w > 0), 32'd1);
    if (d == 0) begin tx_data0 = data; tx_valid0 = 1'b1; end
    else        begin tx_data3 = data; tx_valid3 = 1'b1; end
    @(posedge clk); #1;
    tx_valid0 = 1'b0; tx_valid3 = 1'b0;
    acc_sr0 = n_sr0; acc_cshi0 = n_cshi0;
  endtask

  task automatic send(input int d, input logic [7:0] data, output int lat);
    accept(d, data);
    wait_for(d == 0 ? 1 : 4, 100, lat);
    check("rx_valid_seen", 32'(lat > 0), 32'd1);
  endtask

  task automatic end_session(input int d);
    int c;
    c = (d == 0) ? n_clr0 : n_clr3;
    ctl(d, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("clear_pulses", 32'((d == 0 ? n_clr0 : n_clr3) - c), 32'd1);
    check("status_low", 32'(d == 0 ? status0 : status3), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, lat2, s0, s1, s2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk0", 32'(sclk0), 32'd0);
    check("rst_cs_n0", 32'(cs_n0), 32'h3);
    check("rst_mosi0", 32'(mosi0), 32'd0);
    check("rst_rx_data0", 32'(rx_data0), 32'h00);
    check("rst_flags0", 32'({tx_ready0, rx_valid0, status0, clr0}), 32'h0);
    check("rst_sclk3", 32'(sclk3), 32'd1);
    check("rst_cs_n3", 32'(cs_n3), 32'h3);
    rst_n = 1'b1;

    // T1: mode 0 loopback
    ctl(0, 1'b1, 1'b0, 1'b0);
    check("t1_status", 32'(status0), 32'd1);
    send(0, 8'hA5, lat);
    check("t1_latency", 32'(lat), 32'd37);
    check("t1_rx_data", 32'(rx_data0), 32'hA5);
    check("t1_sclk_rises", 32'(n_sr0 - acc_sr0), 32'd8);
    check("t1_cs_low", 32'(n_cshi0 - acc_cshi0), 32'd0);
    check("t1_sclk_idle", 32'(sclk0), 32'd0);
    end_session(0);

    // T3: three words in one frame; a start mid-session is ignored
    ctl(0, 1'b1, 1'b0, 1'b0);
    s0 = n_cshi0; s1 = n_rxv0;
    send(0, 8'h01, lat);
    check("t3_rx0", 32'(rx_data0), 32'h01);
    ctl(0, 1'b1, 1'b0, 1'b1);
    check("t3_restart_ignored", 32'(cs_n0), 32'h2);
    send(0, 8'h02, lat);
    check("t3_rx1", 32'(rx_data0), 32'h02);
    send(0, 8'h03, lat);
    check("t3_rx2", 32'(rx_data0), 32'h03);
    @(negedge clk);
    check("t3_cs_frame", 32'(n_cshi0 - s0), 32'd0);
    check("t3_rx_pulses", 32'(n_rxv0 - s1), 32'd3);
    end_session(0);
    check("t3_cs_released", 32'(cs_n0), 32'h3);

    // T4: stop during the 4th bit
    ctl(0, 1'b1, 1'b0, 1'b0);
    accept(0, 8'h5A);
    repeat (16) @(negedge clk);
    s0 = n_clr0;
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    s1 = n_rdy0;
    wait_for(1, 100, lat2);
    check("t4_latency", 32'(lat2 + 17), 32'd37);
    check("t4_rx_data", 32'(rx_data0), 32'h5A);
    repeat (4) @(negedge clk);
    check("t4_clear", 32'(n_clr0 - s0), 32'd1);
    check("t4_no_ready", 32'(n_rdy0 - s1), 32'd0);
    check("t4_status", 32'(status0), 32'd0);
    check("t4_cs_n", 32'(cs_n0), 32'h3);

    // T5: asynchronous reset mid-shift
    ctl(0, 1'b1, 1'b0, 1'b0);
    accept(0, 8'h33);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_cs_n", 32'(cs_n0), 32'h3);
    check("t5_sclk", 32'(sclk0), 32'd0);
    check("t5_status", 32'(status0), 32'd0);
    s0 = n_rxv0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_no_rx_valid", 32'(n_rxv0 - s0), 32'd0);
    ctl(0, 1'b1, 1'b0, 1'b0);
    send(0, 8'h96, lat);
    check("t5_after_reset_rx", 32'(rx_data0), 32'h96);
    end_session(0);

    // T6: ignored controls in IDLE, then target select 1
    s0 = n_clr0; s1 = n_rdy0;
    ctl(0, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_startstop_status", 32'(status0), 32'd0);
    check("t6_startstop_cs", 32'(cs_n0), 32'h3);
    ctl(0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_stop_no_clear", 32'(n_clr0 - s0), 32'd0);
    check("t6_no_ready", 32'(n_rdy0 - s1), 32'd0);
    ctl(0, 1'b1, 1'b0, 1'b1);
    wait_for(0, 20, s2);
    check("t6_ready_seen", 32'(s2 > 0), 32'd1);
    check("t6_cs_sel1", 32'(cs_n0), 32'h1);
    end_session(0);
    check("t6_cs_released", 32'(cs_n0), 32'h3);

    // T2: CPOL=1 CPHA=1 LSB first against slave model
    ctl(3, 1'b1, 1'b0, 1'b0);
    send(3, 8'h3C, lat);
    check("t2_latency", 32'(lat), 32'd37);
    check("t2_rx_data", 32'(rx_data3), 32'hC3);
    check("t2_mosi_bits", 32'(mosi_cap), 32'h3C);
    check("t2_sclk_idle", 32'(sclk3), 32'd1);
    end_session(3);
    check("t2_sclk_idle_end", 32'(sclk3), 32'd1);

    check("rx_valid_vs_tx_ready", 32'(n_both), 32'd0);
    check("clear_with_status", 32'(n_clrst), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
